nco_voice_bank: RTL and testbench
=================================

Name: nco_voice_bank

Overview:
Upstream audio source for the I2S transmitter. It divides the 24.576 MHz clk into the transmitter's bit_clk_en and a once-per-frame sample_tick. On each tick it computes one mixed sample from NUM_VOICES phase-accumulator NCO voices, processed one voice per clk. The saturated 16-bit signed result is presented on new_sound_sample, which the transmitter banks at its frame boundary.

Parameters:
NUM_VOICES, 4, number of time-multiplexed NCO voices (>=1)
PHASE_W, 24, phase accumulator and frequency word width (>=16)
BCLK_DIV, 8, clk cycles per bit_clk_en pulse (24.576 MHz / 8 = 3.072 MHz bit rate, 96 kHz frames)
VOICE_SHIFT, 1, arithmetic right shift applied to each voice before summing
Constraint: NUM_VOICES+2 < BCLK_DIV*32 (elaboration-time check).

Ports:
clk  in  1  24.576 MHz system clock
rst  in  1  asynchronous, active-low reset
voice_en  in  NUM_VOICES  per-voice enable
freq_wr_en  in  1  frequency word write strobe
freq_wr_addr  in  $clog2(NUM_VOICES) (min 1)  voice index for write
freq_wr_data  in  PHASE_W  phase increment per sample
wave_sel  in  2  00 saw, 01 square, 10 triangle, 11 silence (global to all voices)
bit_clk_en  out  1  one-clk enable pulse every BCLK_DIV clks, feeds transmitter
sample_tick  out  1  one-clk pulse once per 32 bit_clk_en pulses
new_sound_sample  out  16  signed two's-complement mixed sample
clip  out  1  one-clk pulse when the current sample saturated

Behaviour:
- Reset (async, rst=0): div_cnt=0, frame_cnt=31, FSM=IDLE, all phase and freq registers=0, acc=0. Outputs: bit_clk_en=0, sample_tick=0, new_sound_sample=0, clip=0. Reset mid-computation aborts the sample; no partial update.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. bit_clk_en (registered) is high for the one clk following the edge where div_cnt==BCLK_DIV-1. First pulse occurs in the 8th clk cycle after reset release.
- Frame: frame_cnt is 5-bit and increments on each bit_clk_en, wrapping 31->0. sample_tick is high in the same cycle as bit_clk_en when frame_cnt==31. The first bit_clk_en after reset is therefore a tick; period is 32*BCLK_DIV = 256 clks. This aligns with the transmitter's counter, which resets to 31.
- Frequency writes: when freq_wr_en=1, freq[freq_wr_addr] <= freq_wr_data. Writes are accepted at any time. If a voice is processed in the same cycle as its write, it uses the old value.
- wave_sel: captured into wave_q in the sample_tick cycle and held for that computation.
- FSM states:
  - IDLE: on sample_tick=1 go to ACC with idx=0, acc=0.
  - ACC: one voice per clk. If voice_en[idx]=1: pn = phase[idx]+freq[idx] mod 2^PHASE_W, phase[idx] <= pn, acc += wave(pn) >>> VOICE_SHIFT. If voice_en[idx]=0: phase[idx] <= 0 and contribution is 0. idx++. After idx=NUM_VOICES-1 go to SAT.
  - SAT: new_sound_sample <= clamp(acc, -32768, 32767); clip <= (acc out of range); go to IDLE.
- Latency: new_sound_sample and the clip pulse become visible NUM_VOICES+2 clks after the sample_tick cycle. new_sound_sample holds until the next update. The transmitter therefore samples the value computed one frame earlier.
- Waveforms: p = pn[PHASE_W-1 -: 16], unsigned.
  - saw = p - 32768.
  - square = p[15] ? -32768 : 32767.
  - triangle = p[15]==0 ? 2*p[14:0] - 32768 : 32767 - 2*p[14:0].
  - silence = 0.
- Widths: wave value is 16-bit signed. acc is signed, 17+$clog2(NUM_VOICES) bits, so it never overflows before the clamp.
- A sample_tick arriving outside IDLE cannot occur given the parameter constraint. The FSM ignores ticks when not in IDLE.

Test Plan:
1. Release reset, hold inputs 0 -> bit_clk_en every 8 clks, first in cycle 8. sample_tick coincides with the 1st, 33rd, 65th bit_clk_en (256-clk period). new_sound_sample stays 0, clip never pulses.
2. freq[0]=0x100000, voice_en=0001, wave_sel=00 -> after tick 1: -14336 (p=0x1000). Tick 2: -12288. Each value appears 6 clks after its tick.
3. All 4 voices freq=0x000100, enabled, wave_sel=01 -> each voice contributes 16383, sum 65532 -> new_sound_sample=32767 and clip pulses for 1 clk. Voices 0-1 only -> 32766, no clip.
4. Step 2 running for 3 ticks, then clear voice_en[0] for one tick, then re-enable -> output 0 on the disabled tick. On the following tick the output is -28672>>>1 = -14336 (phase restarted from 0).
5. wave_sel=10, freq[0]=0x400000, voice 0 only -> sequence over ticks 1-4: 0, 16383, -1 (p=0xC000: 32767-32768), -16384.
6. Assert rst 2 clks after a sample_tick (mid-ACC) -> all outputs 0 immediately, async. After release, timing restarts as in scenario 1 and freq registers read 0.

Source files
------------

// File: rtl/nco_voice_bank_if.sv
// Control/data bundle between the NCO voice bank and its controller/transmitter.
// slave = the voice bank itself, master = whoever drives voices and consumes samples.
interface nco_voice_bank_if #(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24
);
  localparam int ADDR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_VOICES-1:0] voice_en;
  logic                  freq_wr_en;
  logic [ADDR_W-1:0]     freq_wr_addr;
  logic [PHASE_W-1:0]    freq_wr_data;
  logic [1:0]            wave_sel;
  logic                  bit_clk_en;
  logic                  sample_tick;
  logic [15:0]           new_sound_sample;
  logic                  clip;

  modport slave (
    input  voice_en, freq_wr_en, freq_wr_addr, freq_wr_data, wave_sel,
    output bit_clk_en, sample_tick, new_sound_sample, clip
  );

  modport master (
    output voice_en, freq_wr_en, freq_wr_addr, freq_wr_data, wave_sel,
    input  bit_clk_en, sample_tick, new_sound_sample, clip
  );
endinterface

// File: rtl/nco_voice_bank.sv
// Time-multiplexed NCO voice bank: bit-clock/frame divider plus one mixed,
// saturated 16-bit sample per frame, one voice evaluated per clk.
module nco_voice_bank #(
  parameter int NUM_VOICES  = 4,
  parameter int PHASE_W     = 24,
  parameter int BCLK_DIV    = 8,
  parameter int VOICE_SHIFT = 1
) (
  input  logic                clk,
  input  logic                rst,
  nco_voice_bank_if.slave     bus
);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = 17 + $clog2(NUM_VOICES);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  generate
    if ((NUM_VOICES < 1) || (NUM_VOICES + 2 >= BCLK_DIV * 32)) begin : g_bad_cfg
      $error("nco_voice_bank: NUM_VOICES must be >=1 and NUM_VOICES+2 < BCLK_DIV*32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  // Divider and frame counter
  logic [DIV_W-1:0] div_cnt_q;
  logic [4:0]       frame_cnt_q;
  logic             bit_clk_en_q;
  logic             sample_tick_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      frame_cnt_q   <= 5'd31;
      bit_clk_en_q  <= 1'b0;
      sample_tick_q <= 1'b0;
    end else begin
      bit_clk_en_q  <= (div_cnt_q == DIV_W'(BCLK_DIV - 1));
      // frame_cnt only advances after the bit_clk_en cycle, so the pulse
      // generated while it still reads 31 becomes the frame tick.
      sample_tick_q <= (div_cnt_q == DIV_W'(BCLK_DIV - 1)) && (frame_cnt_q == 5'd31);
      div_cnt_q     <= (div_cnt_q == DIV_W'(BCLK_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
      if (bit_clk_en_q) begin
        frame_cnt_q <= frame_cnt_q + 5'd1;
      end
    end
  end

  // Per-voice phase and frequency registers
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] freq_q  [NUM_VOICES];
  logic               phase_we;
  logic [PHASE_W-1:0] phase_wdata;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [1:0]               wave_q, wave_d;
  logic [15:0]              sample_q, sample_d;
  logic                     clip_q, clip_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        freq_q[i]  <= '0;
      end
    end else begin
      if (phase_we) begin
        phase_q[idx_q] <= phase_wdata;
      end
      if (bus.freq_wr_en && (int'(bus.freq_wr_addr) < NUM_VOICES)) begin
        freq_q[bus.freq_wr_addr] <= bus.freq_wr_data;
      end
    end
  end

  // Waveform of the voice currently addressed by idx_q
  logic [PHASE_W-1:0]      pn;
  logic [15:0]             p;
  logic [15:0]             wave_val;
  logic signed [ACC_W-1:0] wave_ext;
  logic signed [ACC_W-1:0] contrib;

  always_comb begin
    pn = phase_q[idx_q] + freq_q[idx_q];
    p  = pn[PHASE_W-1 -: 16];
    wave_val = 16'h0000;
    case (wave_q)
      2'b00:   wave_val = {~p[15], p[14:0]};
      2'b01:   wave_val = p[15] ? 16'h8000 : 16'h7FFF;
      2'b10:   wave_val = p[15] ? (16'h7FFF - {p[14:0], 1'b0}) : {~p[14], p[13:0], 1'b0};
      default: wave_val = 16'h0000;
    endcase
    wave_ext = {{(ACC_W-16){wave_val[15]}}, wave_val};
    contrib  = wave_ext >>> VOICE_SHIFT;
  end

  // Sample FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      wave_q   <= 2'b00;
      sample_q <= 16'h0000;
      clip_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      wave_q   <= wave_d;
      sample_q <= sample_d;
      clip_q   <= clip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    wave_d      = wave_q;
    sample_d    = sample_q;
    clip_d      = 1'b0;
    phase_we    = 1'b0;
    phase_wdata = pn;
    case (state_q)
      IDLE: begin
        if (sample_tick_q) begin
          state_d = ACC;
          idx_d   = '0;
          acc_d   = '0;
          wave_d  = bus.wave_sel;
        end
      end
      ACC: begin
        phase_we = 1'b1;
        // A disabled voice restarts from phase 0 when it is re-enabled.
        if (bus.voice_en[idx_q]) begin
          phase_wdata = pn;
          acc_d       = acc_q + contrib;
        end else begin
          phase_wdata = '0;
        end
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = SAT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SAT: begin
        state_d = IDLE;
        if (acc_q > SAT_MAX) begin
          sample_d = 16'h7FFF;
          clip_d   = 1'b1;
        end else if (acc_q < SAT_MIN) begin
          sample_d = 16'h8000;
          clip_d   = 1'b1;
        end else begin
          sample_d = acc_q[15:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bit_clk_en       = bit_clk_en_q;
  assign bus.sample_tick      = sample_tick_q;
  assign bus.new_sound_sample = sample_q;
  assign bus.clip             = clip_q;
endmodule

// File: tb/tb_nco_voice_bank.sv
// Directed bench for nco_voice_bank: divider timing, waveforms, mixing,
// saturation, voice restart and asynchronous reset.
module tb_nco_voice_bank;
  logic clk;
  logic rst;
  int passes = 0;
  int total  = 0;
  logic signed [31:0] last_exp;

  nco_voice_bank_if #(.NUM_VOICES(4), .PHASE_W(24)) bus ();

  nco_voice_bank #(
    .NUM_VOICES(4), .PHASE_W(24), .BCLK_DIV(8), .VOICE_SHIFT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic write_freq(input int addr, input logic [23:0] data);
    bus.freq_wr_en   = 1'b1;
    bus.freq_wr_addr = 2'(addr);
    bus.freq_wr_data = data;
    @(negedge clk);
    bus.freq_wr_en   = 1'b0;
    $display("write freq[%0d] = 0x%06h", addr, data);
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    while (bus.sample_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick"}, 32'(bus.sample_tick === 1'b1), 1);
  endtask

  // Finds the next tick, then checks hold at +5, update and clip at +6, clip low at +7.
  task automatic sample_after_tick(input string tag, input int exp_val, input bit exp_clip);
    wait_tick(tag);
    repeat (5) @(negedge clk);
    chk({tag, "_held"}, $signed(bus.new_sound_sample), last_exp);
    @(negedge clk);
    chk({tag, "_sample"}, $signed(bus.new_sound_sample), exp_val);
    chk({tag, "_clip"}, 32'(bus.clip), 32'(exp_clip));
    @(negedge clk);
    chk({tag, "_clip_end"}, 32'(bus.clip), 0);
    $display("%s: sample=%0d clip=%0b (expected %0d/%0b)", tag,
             $signed(bus.new_sound_sample), exp_clip, exp_val, exp_clip);
    last_exp = exp_val;
  endtask

  task automatic check_startup(input string tag);
    logic [7:0] hist;
    hist = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      hist[k-1] = bus.bit_clk_en;
    end
    chk({tag, "_bce_first"}, 32'(hist), 32'h80);
    chk({tag, "_tick_first"}, 32'(bus.sample_tick), 1);
    $display("%s: bit_clk_en history=0x%02h tick=%0b", tag, hist, bus.sample_tick);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bce"}, 32'(bus.bit_clk_en), 0);
    chk({tag, "_tick"}, 32'(bus.sample_tick), 0);
    chk({tag, "_sample"}, $signed(bus.new_sound_sample), 0);
    chk({tag, "_clip"}, 32'(bus.clip), 0);
    $display("%s: outputs bce=%0b tick=%0b sample=%0d clip=%0b", tag,
             bus.bit_clk_en, bus.sample_tick, $signed(bus.new_sound_sample), bus.clip);
  endtask

  initial begin
    int cyc, bce_cnt, clip_cnt, nz_cnt;
    rst = 1'b0;
    bus.voice_en     = '0;
    bus.freq_wr_en   = 1'b0;
    bus.freq_wr_addr = '0;
    bus.freq_wr_data = '0;
    bus.wave_sel     = 2'b00;
    last_exp         = 0;

    // Reset state and divider/frame timing with everything idle
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    check_startup("s1");
    cyc = 0; bce_cnt = 0; clip_cnt = 0; nz_cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      cyc = c;
      if (bus.bit_clk_en) bce_cnt++;
      if (bus.clip) clip_cnt++;
      if (bus.new_sound_sample != 16'h0000) nz_cnt++;
      if (bus.sample_tick) break;
    end
    chk("s1_tick_period", cyc, 256);
    chk("s1_bce_per_frame", bce_cnt, 32);
    chk("s1_no_clip", clip_cnt, 0);
    chk("s1_silent", nz_cnt, 0);
    $display("s1: period=%0d bce=%0d clips=%0d nonzero=%0d", cyc, bce_cnt, clip_cnt, nz_cnt);
    repeat (10) @(negedge clk);

    // Single saw voice, then disable/re-enable restart
    write_freq(0, 24'h100000);
    bus.voice_en = 4'b0001;
    bus.wave_sel = 2'b00;
    sample_after_tick("s2_t1", -14336, 1'b0);
    sample_after_tick("s2_t2", -12288, 1'b0);
    sample_after_tick("s4_t3", -10240, 1'b0);
    bus.voice_en = 4'b0000;
    sample_after_tick("s4_off", 0, 1'b0);
    bus.voice_en = 4'b0001;
    sample_after_tick("s4_on", -14336, 1'b0);

    // Square on all voices saturates; two voices do not
    for (int a = 0; a < 4; a++) write_freq(a, 24'h000100);
    bus.voice_en = 4'b1111;
    bus.wave_sel = 2'b01;
    sample_after_tick("s3_all", 32767, 1'b1);
    bus.voice_en = 4'b0011;
    sample_after_tick("s3_two", 32766, 1'b0);

    // Triangle on voice 0 from phase 0, then silence
    bus.voice_en = 4'b0000;
    sample_after_tick("s5_clr", 0, 1'b0);
    write_freq(0, 24'h400000);
    bus.voice_en = 4'b0001;
    bus.wave_sel = 2'b10;
    sample_after_tick("s5_t1", 0, 1'b0);
    sample_after_tick("s5_t2", 16383, 1'b0);
    sample_after_tick("s5_t3", -1, 1'b0);
    sample_after_tick("s5_t4", -16384, 1'b0);
    bus.wave_sel = 2'b11;
    sample_after_tick("silence", 0, 1'b0);

    // Negative saturation: every voice at the low square level
    for (int a = 0; a < 4; a++) write_freq(a, 24'h800000);
    bus.voice_en = 4'b1111;
    bus.wave_sel = 2'b01;
    sample_after_tick("neg_sat", -32768, 1'b1);

    // Asynchronous reset in the middle of a computation
    wait_tick("s6");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("s6_async");
    repeat (3) @(negedge clk);
    check_reset_outputs("s6_hold");
    bus.voice_en = 4'b1111;
    bus.wave_sel = 2'b00;
    last_exp = 0;
    rst = 1'b1;
    check_startup("s6");
    // Frequencies cleared: all voices at p=0 give saw -16384 each, clamped low
    sample_after_tick("s6_t1", -32768, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
